// File: rtl/demux2_pkg.sv
// Shared constants for the registered 1-to-2 demultiplexer (demux2_reg).
package demux2_pkg;

   localparam logic SEL_Y0 = 1'b0;
   localparam logic SEL_Y1 = 1'b1;

   localparam int N_DEFAULT  = 16;
   localparam int CW_DEFAULT = 8;

endpackage : demux2_pkg

// File: rtl/demux2_reg_out_slot.sv
// One output holding register of demux2_reg: a full flag plus the word it holds.
// can_load is high when the slot is empty or being drained this cycle.
module out_slot
   import demux2_pkg::*;
#(
   parameter int n = N_DEFAULT
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [n-1:0] load_data,
   input  logic         rdy,
   output logic         valid,
   output logic [n-1:0] data,
   output logic         can_load
);

   logic         full;
   logic [n-1:0] data_q;

   // Load takes priority over drain so a simultaneous drain+load keeps full set.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         full   <= 1'b0;
         data_q <= '0;
      end else if (load) begin
         full   <= 1'b1;
         data_q <= load_data;
      end else if (full && rdy) begin
         full   <= 1'b0;
      end
   end

   assign valid    = full;
   assign data     = data_q;
   assign can_load = !full || rdy;

endmodule : out_slot

// File: rtl/demux2_reg.sv
// Registered 1-to-2 demultiplexer with valid/ready on every port.
// Optional per-output handshake counters are compiled in with DEMUX2_REG_CNT_EN.
module demux2_reg
   import demux2_pkg::*;
#(
   parameter int n  = N_DEFAULT,
   parameter int CW = CW_DEFAULT
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [n-1:0]  D,
   input  logic          S,
   input  logic          DV,
   output logic          DRDY,
   output logic [n-1:0]  Y0,
   output logic          Y0V,
   input  logic          Y0RDY,
   output logic [n-1:0]  Y1,
   output logic          Y1V,
`ifdef DEMUX2_REG_CNT_EN
   input  logic          Y1RDY,
   input  logic          CNT_CLR,
   output logic [CW-1:0] CNT0,
   output logic [CW-1:0] CNT1
`else
   input  logic          Y1RDY
`endif
);

   // Handshake: a word moves on a rising edge when valid and ready are both
   // high; valid never waits on ready, and a stalled producer keeps D/S stable.

   if (CW < 1) begin : g_bad_cw
      $error("demux2_reg: CW must be at least 1");
   end

   logic can0;
   logic can1;
   logic acc;
   logic load0;
   logic load1;

   // Only the selected output decides readiness, even with DV low.
   assign DRDY  = (S == SEL_Y1) ? can1 : can0;
   assign acc   = DV && DRDY;
   assign load0 = acc && (S == SEL_Y0);
   assign load1 = acc && (S == SEL_Y1);

   out_slot #(.n(n)) u_slot0 (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load0),
      .load_data (D),
      .rdy       (Y0RDY),
      .valid     (Y0V),
      .data      (Y0),
      .can_load  (can0)
   );

   out_slot #(.n(n)) u_slot1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load1),
      .load_data (D),
      .rdy       (Y1RDY),
      .valid     (Y1V),
      .data      (Y1),
      .can_load  (can1)
   );

`ifdef DEMUX2_REG_CNT_EN
   // Counters wrap naturally; a clear beats a same-cycle handshake.
   always_ff @(posedge clk) begin
      if (!rst_n || CNT_CLR) begin
         CNT0 <= '0;
         CNT1 <= '0;
      end else begin
         if (Y0V && Y0RDY) CNT0 <= CNT0 + CW'(1);
         if (Y1V && Y1RDY) CNT1 <= CNT1 + CW'(1);
      end
   end
`endif

   // A stalled producer may withdraw DV but must not alter D or S while offering.
   property p_producer_hold;
      @(posedge clk) disable iff (!rst_n)
         (DV && !DRDY) |=> (!DV || ($stable(D) && $stable(S)));
   endproperty
   a_producer_hold: assert property (p_producer_hold);

endmodule : demux2_reg

// File: tb/tb_demux2_reg.sv
// Directed bench for demux2_reg; counter checks run when DEMUX2_REG_CNT_EN is defined.
module tb_demux2_reg;

   localparam int N  = 16;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [N-1:0]  D;
   logic          S;
   logic          DV;
   logic          DRDY;
   logic [N-1:0]  Y0;
   logic          Y0V;
   logic          Y0RDY;
   logic [N-1:0]  Y1;
   logic          Y1V;
   logic          Y1RDY;
`ifdef DEMUX2_REG_CNT_EN
   logic          CNT_CLR;
   logic [CW-1:0] CNT0;
   logic [CW-1:0] CNT1;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   logic [N-1:0] exp_q[$];

   always #5 clk = ~clk;

   demux2_reg #(.n(N), .CW(CW)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .D       (D),
      .S       (S),
      .DV      (DV),
      .DRDY    (DRDY),
      .Y0      (Y0),
      .Y0V     (Y0V),
      .Y0RDY   (Y0RDY),
      .Y1      (Y1),
      .Y1V     (Y1V),
`ifdef DEMUX2_REG_CNT_EN
      .Y1RDY   (Y1RDY),
      .CNT_CLR (CNT_CLR),
      .CNT0    (CNT0),
      .CNT1    (CNT1)
`else
      .Y1RDY   (Y1RDY)
`endif
   );

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; DV = 1'b1; S = 1'b0; D = 16'hFFFF;
      Y0RDY = 1'b0; Y1RDY = 1'b0;
      repeat (2) next_cycle();
      @(negedge clk);
      n_checks++; if (Y0V !== 1'b0) begin n_fail++; $display("FAIL reset_y0v got %b exp 0", Y0V); end
      n_checks++; if (Y1V !== 1'b0) begin n_fail++; $display("FAIL reset_y1v got %b exp 0", Y1V); end
      n_checks++; if (Y0 !== 16'h0) begin n_fail++; $display("FAIL reset_y0 got %h exp 0000", Y0); end
      n_checks++; if (Y1 !== 16'h0) begin n_fail++; $display("FAIL reset_y1 got %h exp 0000", Y1); end
      next_cycle();
      rst_n = 1'b1; DV = 1'b0;
      @(negedge clk);
      n_checks++; if (Y0V !== 1'b0) begin n_fail++; $display("FAIL reset_no_accept got %b exp 0", Y0V); end
      next_cycle();
   endtask

   task automatic test_alternating();
      Y0RDY = 1'b1; Y1RDY = 1'b1;
      DV = 1'b1; S = 1'b0; D = 16'h1111;
      @(negedge clk);
      n_checks++; if (DRDY !== 1'b1) begin n_fail++; $display("FAIL alt_drdy0 got %b exp 1", DRDY); end
      next_cycle();
      S = 1'b1; D = 16'h2222;
      @(negedge clk);
      n_checks++; if (DRDY !== 1'b1) begin n_fail++; $display("FAIL alt_drdy1 got %b exp 1", DRDY); end
      n_checks++; if (Y0V !== 1'b1 || Y0 !== 16'h1111) begin n_fail++; $display("FAIL alt_y0_first got %b/%h exp 1/1111", Y0V, Y0); end
      next_cycle();
      S = 1'b0; D = 16'h3333;
      @(negedge clk);
      n_checks++; if (DRDY !== 1'b1) begin n_fail++; $display("FAIL alt_drdy2 got %b exp 1", DRDY); end
      n_checks++; if (Y1V !== 1'b1 || Y1 !== 16'h2222) begin n_fail++; $display("FAIL alt_y1 got %b/%h exp 1/2222", Y1V, Y1); end
      n_checks++; if (Y0V !== 1'b0) begin n_fail++; $display("FAIL alt_y0_drained got %b exp 0", Y0V); end
      next_cycle();
      DV = 1'b0;
      @(negedge clk);
      n_checks++; if (Y0V !== 1'b1 || Y0 !== 16'h3333) begin n_fail++; $display("FAIL alt_y0_second got %b/%h exp 1/3333", Y0V, Y0); end
      n_checks++; if (Y1V !== 1'b0) begin n_fail++; $display("FAIL alt_y1_drained got %b exp 0", Y1V); end
      next_cycle();
   endtask

   task automatic test_stall();
      Y0RDY = 1'b0; Y1RDY = 1'b1;
      DV = 1'b1; S = 1'b0; D = 16'hAAAA;
      @(negedge clk);
      n_checks++; if (DRDY !== 1'b1) begin n_fail++; $display("FAIL stall_first_drdy got %b exp 1", DRDY); end
      next_cycle();
      D = 16'hBBBB;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         n_checks++; if (DRDY !== 1'b0) begin n_fail++; $display("FAIL stall_drdy_low got %b exp 0", DRDY); end
         n_checks++; if (Y0V !== 1'b1 || Y0 !== 16'hAAAA) begin n_fail++; $display("FAIL stall_y0_hold got %b/%h exp 1/aaaa", Y0V, Y0); end
         next_cycle();
      end
      DV = 1'b0; S = 1'b1;
      @(negedge clk);
      n_checks++; if (DRDY !== 1'b1) begin n_fail++; $display("FAIL stall_switch_drdy got %b exp 1", DRDY); end
      next_cycle();
      DV = 1'b1; D = 16'hCCCC;
      @(negedge clk);
      n_checks++; if (DRDY !== 1'b1) begin n_fail++; $display("FAIL stall_y1_drdy got %b exp 1", DRDY); end
      next_cycle();
      DV = 1'b0;
      @(negedge clk);
      n_checks++; if (Y1V !== 1'b1 || Y1 !== 16'hCCCC) begin n_fail++; $display("FAIL stall_y1_word got %b/%h exp 1/cccc", Y1V, Y1); end
      n_checks++; if (Y0V !== 1'b1 || Y0 !== 16'hAAAA) begin n_fail++; $display("FAIL stall_y0_still got %b/%h exp 1/aaaa", Y0V, Y0); end
      next_cycle();
      Y0RDY = 1'b1;
      next_cycle();
      @(negedge clk);
      n_checks++; if (Y0V !== 1'b0 || Y1V !== 1'b0) begin n_fail++; $display("FAIL stall_release got %b%b exp 00", Y0V, Y1V); end
      next_cycle();
   endtask

   task automatic test_drain_load();
      Y0RDY = 1'b0; DV = 1'b1; S = 1'b0; D = 16'h0005;
      next_cycle();
      Y0RDY = 1'b1; D = 16'h0006;
      @(negedge clk);
      n_checks++; if (DRDY !== 1'b1) begin n_fail++; $display("FAIL dl_drdy got %b exp 1", DRDY); end
      n_checks++; if (Y0V !== 1'b1 || Y0 !== 16'h0005) begin n_fail++; $display("FAIL dl_before got %b/%h exp 1/0005", Y0V, Y0); end
      next_cycle();
      DV = 1'b0;
      @(negedge clk);
      n_checks++; if (Y0V !== 1'b1 || Y0 !== 16'h0006) begin n_fail++; $display("FAIL dl_after got %b/%h exp 1/0006", Y0V, Y0); end
      next_cycle();
      @(negedge clk);
      n_checks++; if (Y0V !== 1'b0 || Y0 !== 16'h0006) begin n_fail++; $display("FAIL dl_drain_hold got %b/%h exp 0/0006", Y0V, Y0); end
      next_cycle();
   endtask

   task automatic test_back_to_back();
      logic [N-1:0] exp_w;
      Y1RDY = 1'b1; S = 1'b1; DV = 1'b1;
      for (int i = 0; i < 6; i++) begin
         D = 16'h1000 + 16'(i) * 16'h0111;
         @(negedge clk);
         n_checks++; if (DRDY !== 1'b1) begin n_fail++; $display("FAIL b2b_drdy word %0d got %b exp 1", i, DRDY); end
         if (exp_q.size() > 0) begin
            exp_w = exp_q.pop_front();
            n_checks++; if (Y1V !== 1'b1 || Y1 !== exp_w) begin n_fail++; $display("FAIL b2b_word got %b/%h exp 1/%h", Y1V, Y1, exp_w); end
         end
         exp_q.push_back(D);
         next_cycle();
      end
      DV = 1'b0;
      @(negedge clk);
      exp_w = exp_q.pop_front();
      n_checks++; if (Y1V !== 1'b1 || Y1 !== exp_w) begin n_fail++; $display("FAIL b2b_last got %b/%h exp 1/%h", Y1V, Y1, exp_w); end
      n_checks++; if (Y0V !== 1'b0) begin n_fail++; $display("FAIL b2b_y0_quiet got %b exp 0", Y0V); end
      next_cycle();
   endtask

   task automatic test_reset_mid_stall();
      Y0RDY = 1'b0; Y1RDY = 1'b0;
      DV = 1'b1; S = 1'b0; D = 16'h0101;
      next_cycle();
      S = 1'b1; D = 16'h0202;
      next_cycle();
      DV = 1'b0; S = 1'b0;
      @(negedge clk);
      n_checks++; if (Y0V !== 1'b1 || Y1V !== 1'b1) begin n_fail++; $display("FAIL rms_full got %b%b exp 11", Y0V, Y1V); end
      n_checks++; if (DRDY !== 1'b0) begin n_fail++; $display("FAIL rms_drdy_low got %b exp 0", DRDY); end
      next_cycle();
      rst_n = 1'b0;
      next_cycle();
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++; if (Y0V !== 1'b0 || Y1V !== 1'b0) begin n_fail++; $display("FAIL rms_cleared got %b%b exp 00", Y0V, Y1V); end
      n_checks++; if (DRDY !== 1'b1) begin n_fail++; $display("FAIL rms_drdy got %b exp 1", DRDY); end
      next_cycle();
   endtask

`ifdef DEMUX2_REG_CNT_EN
   task automatic test_counters();
      CNT_CLR = 1'b1;
      next_cycle();
      CNT_CLR = 1'b0;
      Y1RDY = 1'b1; S = 1'b1; DV = 1'b1;
      for (int i = 0; i < 257; i++) begin
         D = 16'(i);
         next_cycle();
      end
      DV = 1'b0;
      next_cycle();
      @(negedge clk);
      n_checks++; if (CNT1 !== 8'd1) begin n_fail++; $display("FAIL cnt1_wrap got %0d exp 1", CNT1); end
      n_checks++; if (CNT0 !== 8'd0) begin n_fail++; $display("FAIL cnt0_idle got %0d exp 0", CNT0); end
      next_cycle();
      DV = 1'b1; D = 16'h7777;
      next_cycle();
      DV = 1'b0; CNT_CLR = 1'b1;
      @(negedge clk);
      n_checks++; if (Y1V !== 1'b1) begin n_fail++; $display("FAIL cnt_clr_setup got %b exp 1", Y1V); end
      next_cycle();
      CNT_CLR = 1'b0;
      @(negedge clk);
      n_checks++; if (CNT1 !== 8'd0) begin n_fail++; $display("FAIL cnt1_clr_wins got %0d exp 0", CNT1); end
      next_cycle();
   endtask
`endif

   initial begin
      rst_n = 1'b0; D = '0; S = 1'b0; DV = 1'b0; Y0RDY = 1'b0; Y1RDY = 1'b0;
`ifdef DEMUX2_REG_CNT_EN
      CNT_CLR = 1'b0;
`endif
      test_reset();
      test_alternating();
      test_stall();
      test_drain_load();
      test_back_to_back();
      test_reset_mid_stall();
`ifdef DEMUX2_REG_CNT_EN
      test_counters();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_demux2_reg
